// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: ALU FIFO, load and link sources share one register-file write port.
// Optional WB_CONFLICT_CNT_EN adds a saturating contention counter output (wb_conflicts).
module wb_port_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned AGE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              lnk_valid,
  output logic              lnk_ready,
  input  logic [ADDR_W-1:0] lnk_rd,
  input  logic [DATA_W-1:0] lnk_pc,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [1:0]        mem_to_reg,
  output logic [DATA_W-1:0] out_from_ALU,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] prog_count,
`ifdef WB_CONFLICT_CNT_EN
  output logic [15:0]       wb_conflicts,
`endif
  output logic              busy
);

  localparam int unsigned AGE_W = (AGE_LIMIT < 1) ? 1 : $clog2(AGE_LIMIT + 1);

  typedef enum logic [1:0] {
    SRC_ALU = 2'b00,
    SRC_MEM = 2'b01,
    SRC_PC  = 2'b10
  } src_t;

  logic [ADDR_W-1:0] fifo_rd   [2];
  logic [DATA_W-1:0] fifo_data [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic [AGE_W-1:0]  age;

  logic              alu_cand;
  logic              fifo_full;
  logic              aging;
  logic              push;
  logic              pop;
  logic              gnt_valid;
  src_t              gnt_src;
  logic [ADDR_W-1:0] gnt_rd;

  assign alu_cand  = (count != 2'd0);
  assign fifo_full = (count == 2'd2);
  assign aging     = (age == AGE_W'(AGE_LIMIT));
  assign alu_ready = !fifo_full;
  assign push      = !rst && alu_valid && !fifo_full;
  assign busy      = alu_cand || alu_valid || ld_valid || lnk_valid;

  // Grants are suppressed during reset so no source believes it was accepted.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_src   = SRC_ALU;
    gnt_rd    = fifo_rd[rd_ptr];
    if (!rst) begin
      if (alu_cand && aging) begin
        gnt_valid = 1'b1;
        gnt_src   = SRC_ALU;
        gnt_rd    = fifo_rd[rd_ptr];
      end else if (ld_valid) begin
        gnt_valid = 1'b1;
        gnt_src   = SRC_MEM;
        gnt_rd    = ld_rd;
      end else if (lnk_valid) begin
        gnt_valid = 1'b1;
        gnt_src   = SRC_PC;
        gnt_rd    = lnk_rd;
      end else if (alu_cand) begin
        gnt_valid = 1'b1;
        gnt_src   = SRC_ALU;
        gnt_rd    = fifo_rd[rd_ptr];
      end
    end
  end

  assign pop       = gnt_valid && (gnt_src == SRC_ALU);
  assign ld_ready  = ld_valid && gnt_valid && (gnt_src == SRC_MEM);
  assign lnk_ready = lnk_valid && gnt_valid && (gnt_src == SRC_PC);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      age          <= '0;
      reg_write    <= 1'b0;
      write_reg    <= '0;
      mem_to_reg   <= SRC_ALU;
      out_from_ALU <= '0;
      data_out     <= '0;
      prog_count   <= '0;
    end else begin
      if (push) begin
        fifo_rd[wr_ptr]   <= alu_rd;
        fifo_data[wr_ptr] <= alu_data;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase

      if (!fifo_full || pop)
        age <= '0;
      else if (!aging)
        age <= age + AGE_W'(1);

      reg_write  <= gnt_valid && (gnt_rd != '0);
      mem_to_reg <= gnt_valid ? gnt_src : SRC_ALU;
      if (gnt_valid) begin
        write_reg <= gnt_rd;
        case (gnt_src)
          SRC_MEM: data_out     <= ld_data;
          SRC_PC:  prog_count   <= lnk_pc;
          default: out_from_ALU <= fifo_data[rd_ptr];
        endcase
      end
    end
  end

`ifdef WB_CONFLICT_CNT_EN
  logic multi_cand;
  assign multi_cand = (ld_valid && lnk_valid) || (ld_valid && alu_cand) || (lnk_valid && alu_cand);

  always_ff @(posedge clk) begin
    if (rst)
      wb_conflicts <= '0;
    else if (multi_cand && (wb_conflicts != '1))
      wb_conflicts <= wb_conflicts + 16'd1;
  end
`endif

endmodule
